// File: rtl/ysyx_23060208_mem_arbiter.sv
// Shares one memory port between IFU reads and LSU loads/stores: round-robin on ties,
// a single transaction outstanding, responses forwarded straight to the owner.
module ysyx_23060208_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    ifu_req_valid,
  input  logic [ADDR_WIDTH-1:0]   ifu_req_addr,
  output logic                    ifu_req_ready,
  output logic                    ifu_resp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_resp_rdata,

  input  logic                    lsu_req_valid,
  input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
  input  logic                    lsu_req_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_req_wstrb,
  output logic                    lsu_req_ready,
  output logic                    lsu_resp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_resp_rdata,

  output logic                    mem_req_valid,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic                    mem_req_wen,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
  input  logic                    mem_req_ready,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_rdata,

  output logic                    busy,
  output logic                    proto_err
);

  // state     | meaning
  // IDLE      | nothing outstanding; arbitrate and accept at most one request
  // ISSUE     | latched request presented on mem_req_*, waiting for mem_req_ready
  // WAIT_RESP | memory took the request, waiting for mem_resp_valid

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  state_t                  state;
  owner_t                  last_owner;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    wen_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    mem_req_valid_q;
  logic                    busy_q;
  logic                    proto_err_q;

  logic                    pick_lsu;
  logic                    pick_ifu;
  logic                    grant_en;
  logic                    resp_fire;

  // last_owner doubles as the current owner while a transaction is open
  always_comb begin
    pick_lsu = lsu_req_valid && (!ifu_req_valid || (last_owner == OWN_IFU));
    pick_ifu = ifu_req_valid && !pick_lsu;
  end

  // readies are combinational on the inputs, so hold them off while in reset
  assign grant_en  = rst && (state == IDLE);
  assign resp_fire = (state == WAIT_RESP) && mem_resp_valid;

  assign ifu_req_ready  = grant_en && pick_ifu;
  assign lsu_req_ready  = grant_en && pick_lsu;

  assign ifu_resp_valid = resp_fire && (last_owner == OWN_IFU);
  assign lsu_resp_valid = resp_fire && (last_owner == OWN_LSU);
  assign ifu_resp_rdata = ifu_resp_valid ? mem_resp_rdata : '0;
  assign lsu_resp_rdata = (lsu_resp_valid && !wen_q) ? mem_resp_rdata : '0;

  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wstrb  = wstrb_q;

  assign busy           = busy_q;
  assign proto_err      = proto_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      last_owner      <= OWN_IFU;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      mem_req_valid_q <= 1'b0;
      busy_q          <= 1'b0;
      proto_err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_resp_valid) proto_err_q <= 1'b1;
          if (pick_lsu || pick_ifu) begin
            last_owner      <= pick_lsu ? OWN_LSU : OWN_IFU;
            addr_q          <= pick_lsu ? lsu_req_addr : ifu_req_addr;
            wen_q           <= pick_lsu && lsu_req_wen;
            wdata_q         <= pick_lsu ? lsu_req_wdata : '0;
            wstrb_q         <= pick_lsu ? lsu_req_wstrb : '0;
            mem_req_valid_q <= 1'b1;
            busy_q          <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_resp_valid) proto_err_q <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state           <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (mem_resp_valid) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          mem_req_valid_q <= 1'b0;
          busy_q          <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_mem_arbiter.sv
// Bench for the memory arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level reference.
module tb_ysyx_23060208_mem_arbiter;

  logic        clk, rst;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_resp_rdata;
  logic        lsu_req_valid;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wstrb;
  logic        lsu_req_ready, lsu_resp_valid;
  logic [31:0] lsu_resp_rdata;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_req_ready, mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        busy, proto_err;

  int vectors = 0;
  int miscompares = 0;

  // reference: the single open transaction as seen from outside the block
  bit          m_open, m_hs, m_lsu, m_last_lsu, m_perr, m_wen;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  int          mem_delay;

  ysyx_23060208_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr),
    .ifu_req_ready(ifu_req_ready), .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_rdata(ifu_resp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata),
    .lsu_req_wstrb(lsu_req_wstrb), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata),
    .mem_req_wstrb(mem_req_wstrb), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .busy(busy), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(string name, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_hs = 0; m_lsu = 0; m_last_lsu = 0; m_perr = 0; m_wen = 0;
    m_addr = '0; m_wdata = '0; m_wstrb = '0; mem_delay = 0;
  endtask

  // check every output at the falling edge, then move the reference past the rising edge
  task automatic sample();
    bit pick_lsu, pick_ifu, e_ifu_rv, e_lsu_rv;
    @(negedge clk);
    pick_lsu = !m_open && lsu_req_valid && (!ifu_req_valid || !m_last_lsu);
    pick_ifu = !m_open && ifu_req_valid && !pick_lsu;
    e_ifu_rv = m_open && m_hs && !m_lsu && mem_resp_valid;
    e_lsu_rv = m_open && m_hs &&  m_lsu && mem_resp_valid;
    chk1("ifu_req_ready", ifu_req_ready, pick_ifu);
    chk1("lsu_req_ready", lsu_req_ready, pick_lsu);
    chk1("busy", busy, m_open);
    chk1("mem_req_valid", mem_req_valid, m_open && !m_hs);
    if (m_open && !m_hs) begin
      chk32("mem_req_addr", mem_req_addr, m_addr);
      chk1("mem_req_wen", mem_req_wen, m_wen);
      if (!m_lsu || m_wen) chk32("mem_req_wstrb", 32'(mem_req_wstrb), 32'(m_wstrb));
      if (m_lsu && m_wen) chk32("mem_req_wdata", mem_req_wdata, m_wdata);
    end
    chk1("ifu_resp_valid", ifu_resp_valid, e_ifu_rv);
    chk1("lsu_resp_valid", lsu_resp_valid, e_lsu_rv);
    if (e_ifu_rv) chk32("ifu_resp_rdata", ifu_resp_rdata, mem_resp_rdata);
    if (e_lsu_rv) chk32("lsu_resp_rdata", lsu_resp_rdata, m_wen ? 32'h0 : mem_resp_rdata);
    chk1("proto_err", proto_err, m_perr);

    if (!m_open) begin
      if (mem_resp_valid) m_perr = 1;
      if (pick_lsu || pick_ifu) begin
        m_open = 1; m_hs = 0; m_lsu = pick_lsu; m_last_lsu = pick_lsu;
        m_addr  = pick_lsu ? lsu_req_addr : ifu_req_addr;
        m_wen   = pick_lsu && lsu_req_wen;
        m_wdata = lsu_req_wdata;
        m_wstrb = pick_lsu ? lsu_req_wstrb : 4'h0;
      end
    end else if (!m_hs) begin
      if (mem_resp_valid) m_perr = 1;
      if (mem_req_ready) begin
        m_hs = 1;
        mem_delay = $urandom_range(0, 2);
      end
    end else if (mem_resp_valid) begin
      m_open = 0; m_hs = 0;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic dir_txn(string tag, bit iv, bit lv, logic [31:0] ia, logic [31:0] la,
                         bit lw, logic [31:0] lwd, logic [3:0] lws, int stall,
                         logic [31:0] rd, bit exp_lsu);
    ifu_req_valid = iv; ifu_req_addr = ia;
    lsu_req_valid = lv; lsu_req_addr = la; lsu_req_wen = lw;
    lsu_req_wdata = lwd; lsu_req_wstrb = lws;
    mem_req_ready = 0; mem_resp_valid = 0;
    sample();
    chk1({tag, "_lsu_ready"}, lsu_req_ready, exp_lsu);
    chk1({tag, "_ifu_ready"}, ifu_req_ready, !exp_lsu);
    advance();
    for (int i = 0; i <= stall; i++) begin
      mem_req_ready = (i == stall);
      sample();
      chk1({tag, "_issue_valid"}, mem_req_valid, 1'b1);
      chk32({tag, "_issue_addr"}, mem_req_addr, exp_lsu ? la : ia);
      chk1({tag, "_issue_wen"}, mem_req_wen, exp_lsu && lw);
      advance();
    end
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = rd;
    sample();
    chk1({tag, "_own_resp"}, exp_lsu ? lsu_resp_valid : ifu_resp_valid, 1'b1);
    chk1({tag, "_other_resp"}, exp_lsu ? ifu_resp_valid : lsu_resp_valid, 1'b0);
    chk32({tag, "_rdata"}, exp_lsu ? lsu_resp_rdata : ifu_resp_rdata,
          (exp_lsu && lw) ? 32'h0 : rd);
    advance();
    mem_resp_valid = 0; ifu_req_valid = 0; lsu_req_valid = 0;
    sample();
    chk1({tag, "_busy_after"}, busy, 1'b0);
    advance();
  endtask

  task automatic rand_cycle(bit reqs, bit spur);
    ifu_req_valid = reqs && ($urandom_range(0, 1) == 1);
    ifu_req_addr  = $urandom;
    lsu_req_valid = reqs && ($urandom_range(0, 1) == 1);
    lsu_req_addr  = $urandom;
    lsu_req_wen   = ($urandom_range(0, 1) == 1);
    lsu_req_wdata = $urandom;
    lsu_req_wstrb = 4'($urandom_range(0, 15));
    mem_req_ready = ($urandom_range(0, 2) != 0);
    mem_resp_rdata = $urandom;
    if (m_open && m_hs) begin
      if (mem_delay == 0) mem_resp_valid = 1;
      else begin
        mem_resp_valid = 0;
        mem_delay--;
      end
    end else begin
      mem_resp_valid = spur && ($urandom_range(0, 15) == 0);
    end
    sample();
    advance();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_open; i++) rand_cycle(1'b0, 1'b0);
    if (m_open) begin
      miscompares++;
      $display("FAIL drain: transaction still open after 40 cycles");
    end
  endtask

  initial begin
    rst = 0;
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wstrb = 4'hF;
    mem_req_ready = 1; mem_resp_valid = 1; mem_resp_rdata = 32'h1234_5678;
    model_reset();
    #2;
    chk32("rst_ctl", 32'({ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid,
                          mem_req_valid, mem_req_wen, busy, proto_err}), 32'h0);
    chk32("rst_data", ifu_resp_rdata | lsu_resp_rdata | mem_req_addr | mem_req_wdata
                      | 32'(mem_req_wstrb), 32'h0);
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
    advance();
    rst = 1;

    // ties after reset alternate LSU, IFU, LSU; third one stalls the memory 5 cycles
    dir_txn("tie1", 1, 1, 32'h8000_0100, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 0, 32'h0000_0055, 1);
    dir_txn("tie2", 1, 1, 32'h8000_0100, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 0, 32'h0000_0066, 0);
    dir_txn("tie3", 1, 1, 32'h8000_0100, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 5, 32'h0000_0077, 1);
    dir_txn("ifu_rd", 1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 0, 32'h0000_0413, 0);
    dir_txn("lsu_ld", 0, 1, 32'h0, 32'h8000_0004, 0, 32'h0, 4'hF, 0, 32'h1234_5678, 1);

    for (int i = 0; i < 1500; i++) rand_cycle(1'b1, 1'b0);
    drain();

    // stray response while idle
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 0;
    mem_resp_valid = 1; mem_resp_rdata = 32'hBAD0_BAD0;
    sample();
    chk1("spur_no_ifu_resp", ifu_resp_valid, 1'b0);
    chk1("spur_no_lsu_resp", lsu_resp_valid, 1'b0);
    advance();
    mem_resp_valid = 0;
    sample();
    chk1("spur_proto_err", proto_err, 1'b1);
    advance();
    dir_txn("post_spur", 1, 0, 32'h8000_0008, 32'h0, 0, 32'h0, 4'h0, 1, 32'h0000_0099, 0);
    sample();
    chk1("proto_err_sticky", proto_err, 1'b1);
    advance();

    // reset while waiting for the response
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0200; mem_req_ready = 1; mem_resp_valid = 0;
    sample();
    advance();
    ifu_req_valid = 0;
    sample();
    advance();
    chk1("pre_rst_busy", busy, 1'b1);
    #1;
    rst = 0; mem_resp_valid = 1; mem_resp_rdata = 32'hAAAA_5555; ifu_req_valid = 1;
    #1;
    chk32("wait_rst_ctl", 32'({ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid,
                               mem_req_valid, mem_req_wen, busy, proto_err}), 32'h0);
    chk32("wait_rst_data", ifu_resp_rdata | lsu_resp_rdata | mem_req_addr | mem_req_wdata
                           | 32'(mem_req_wstrb), 32'h0);
    model_reset();
    ifu_req_valid = 0; mem_req_ready = 0;
    advance();
    rst = 1;
    sample();
    chk1("late_resp_dropped", ifu_resp_valid, 1'b0);
    chk1("late_resp_perr_before", proto_err, 1'b0);
    advance();
    mem_resp_valid = 0;
    sample();
    chk1("late_resp_perr", proto_err, 1'b1);
    advance();

    for (int i = 0; i < 400; i++) rand_cycle(1'b1, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
